// File: rtl/qtr_pkg.sv
// rtl/qtr_pkg.sv - shared tile geometry, sprite codes and slot record for queue_tile_renderer
package qtr_pkg;

    localparam int TILE      = 30;
    localparam int ROM_DEPTH = TILE * TILE;
    localparam int ADDR_W    = $clog2(ROM_DEPTH);

    localparam logic [2:0] NUM_BLANK = 3'd4;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_GREEN  = 2'd1,
        COL_BLUE   = 2'd2,
        COL_YELLOW = 2'd3
    } color_e;

    typedef struct packed {
        logic [1:0] color;
        logic [2:0] number;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TILE = 2'd1,
        ST_DONE = 2'd2
    } hstate_t;

    // ty*30 as ty*32 - ty*2, keeping the row base multiplier-free
    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] ty);
        logic [ADDR_W-1:0] t;
        t = {{(ADDR_W-5){1'b0}}, ty};
        return (t << 5) - (t << 1);
    endfunction

endpackage

// File: rtl/qtr_slot_regs.sv
// rtl/qtr_slot_regs.sv - per-slot colour/number register file, one write and one read port
module qtr_slot_regs
    import qtr_pkg::*;
#(
    parameter int NSLOT = 8,
    parameter int SW    = $clog2(NSLOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [SW-1:0] wr_idx,
    input  logic [1:0]    wr_color,
    input  logic [2:0]    wr_number,
    input  logic [SW-1:0] rd_idx,
    output logic [1:0]    rd_color,
    output logic [2:0]    rd_number
);

    slot_t regs [NSLOT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                regs[i] <= '{color: COL_RED, number: NUM_BLANK};
            end
        end else if (we) begin
            regs[wr_idx] <= '{color: wr_color, number: wr_number};
        end
    end

    // Read sees the pre-write contents, so a same-cycle snapshot keeps the old value
    assign rd_color  = regs[rd_idx].color;
    assign rd_number = regs[rd_idx].number;

endmodule

// File: rtl/queue_tile_renderer.sv
// rtl/queue_tile_renderer.sv - renders an NSLOT-tile queue strip from the sprite ROM, 3-cycle latency
// Optional macro TILE_BORDER_EN: white frame on the outer ring of each tile.
module queue_tile_renderer
    import qtr_pkg::*;
#(
    parameter int          NSLOT    = 8,
    parameter int          ORG_X    = 100,
    parameter int          ORG_Y    = 400,
    parameter logic [7:0]  BG_COLOR = 8'h00,
    parameter int          SW       = $clog2(NSLOT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pix_valid,
    input  logic              slot_we,
    input  logic [SW-1:0]     slot_idx,
    input  logic [1:0]        slot_color,
    input  logic [2:0]        slot_number,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        rom_color,
    output logic [2:0]        rom_number,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pix_out,
    output logic              pix_out_valid,
    output logic              in_strip
);

    hstate_t       state, state_nx;
    logic [4:0]    tx, tx_nx, tx_c;
    logic [SW-1:0] slot, slot_nx, slot_c;
    logic [9:0]    exp_x, exp_x_nx;
    logic [9:0]    dy;
    logic [4:0]    ty;
    logic          row_hit, entry, cont, hit, border_c;
    logic [1:0]    rd_color, snap_color, cur_color;
    logic [2:0]    rd_number, snap_number, cur_number;
    logic          v1, s1, b1, v2, s2, b2;

    assign dy      = pix_y - 10'(ORG_Y);
    assign row_hit = dy < 10'(TILE);
    assign ty      = dy[4:0];

    assign entry  = (state == ST_IDLE) && pix_valid && row_hit && (pix_x == 10'(ORG_X));
    assign cont   = (state == ST_TILE) && pix_valid && row_hit && (pix_x == exp_x);
    assign hit    = entry || cont;
    assign tx_c   = entry ? 5'd0 : tx;
    assign slot_c = entry ? '0 : slot;

    always_comb begin
        state_nx = state;
        tx_nx    = tx;
        slot_nx  = slot;
        exp_x_nx = exp_x;
        case (state)
            ST_IDLE: if (entry) state_nx = ST_TILE;
            ST_TILE: if (pix_valid && !cont) state_nx = ST_IDLE;
            ST_DONE: if (!pix_valid) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (hit) begin
            exp_x_nx = pix_x + 10'd1;
            if (tx_c == 5'(TILE - 1)) begin
                tx_nx   = 5'd0;
                slot_nx = slot_c + SW'(1);
                if (slot_c == SW'(NSLOT - 1)) state_nx = ST_DONE;
            end else begin
                tx_nx   = tx_c + 5'd1;
                slot_nx = slot_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            tx    <= 5'd0;
            slot  <= '0;
            exp_x <= 10'd0;
        end else begin
            state <= state_nx;
            tx    <= tx_nx;
            slot  <= slot_nx;
            exp_x <= exp_x_nx;
        end
    end

    qtr_slot_regs #(.NSLOT(NSLOT), .SW(SW)) u_slot_regs (
        .clk       (clk),
        .rst       (rst),
        .we        (slot_we),
        .wr_idx    (slot_idx),
        .wr_color  (slot_color),
        .wr_number (slot_number),
        .rd_idx    (slot_c),
        .rd_color  (rd_color),
        .rd_number (rd_number)
    );

    // First pixel of a tile uses the live read; the rest of the tile uses the latched copy
    assign cur_color  = (tx_c == 5'd0) ? rd_color  : snap_color;
    assign cur_number = (tx_c == 5'd0) ? rd_number : snap_number;

`ifdef TILE_BORDER_EN
    assign border_c = (tx_c == 5'd0) || (tx_c == 5'(TILE - 1)) || (ty == 5'd0) || (ty == 5'(TILE - 1));
`else
    assign border_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_color  <= COL_RED;
            snap_number <= NUM_BLANK;
            rom_addr    <= '0;
            rom_color   <= COL_RED;
            rom_number  <= NUM_BLANK;
            v1 <= 1'b0; s1 <= 1'b0; b1 <= 1'b0;
            v2 <= 1'b0; s2 <= 1'b0; b2 <= 1'b0;
            pix_out       <= BG_COLOR;
            pix_out_valid <= 1'b0;
            in_strip      <= 1'b0;
        end else begin
            if (hit && tx_c == 5'd0) begin
                snap_color  <= rd_color;
                snap_number <= rd_number;
            end
            v1 <= pix_valid;
            s1 <= hit;
            b1 <= hit && border_c;
            if (hit) begin
                rom_addr   <= row_base(ty) + {{(ADDR_W-5){1'b0}}, tx_c};
                rom_color  <= cur_color;
                rom_number <= cur_number;
            end else begin
                rom_addr   <= '0;
                rom_color  <= COL_RED;
                rom_number <= NUM_BLANK;
            end
            v2 <= v1;
            s2 <= s1;
            b2 <= b1;
            pix_out       <= s2 ? (b2 ? 8'hFF : rom_data) : BG_COLOR;
            pix_out_valid <= v2;
            in_strip      <= s2;
        end
    end

endmodule

// File: tb/tb_queue_tile_renderer.sv
// tb/tb_queue_tile_renderer.sv - directed bench for queue_tile_renderer with sprite ROM model
module tb_queue_tile_renderer;

    localparam int ORG_X = 100;
    localparam int ORG_Y = 400;
    localparam int TILE  = 30;
    localparam int NSLOT = 8;
    localparam int BG    = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pix_x, pix_y;
    logic       pix_valid, slot_we;
    logic [2:0] slot_idx;
    logic [1:0] slot_color;
    logic [2:0] slot_number;
    logic [9:0] rom_addr;
    logic [1:0] rom_color;
    logic [2:0] rom_number;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] pix_out;
    logic       pix_out_valid, in_strip;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit v;
        bit s;
        int pix;
    } exp_t;

    exp_t q[$];
    int   cur_c[NSLOT];
    int   cur_n[NSLOT];
    int   snap_c, snap_n;
    bit   armed;

    always #5 clk = ~clk;

    queue_tile_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_valid     (pix_valid),
        .slot_we       (slot_we),
        .slot_idx      (slot_idx),
        .slot_color    (slot_color),
        .slot_number   (slot_number),
        .rom_addr      (rom_addr),
        .rom_color     (rom_color),
        .rom_number    (rom_number),
        .rom_data      (rom_data),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .in_strip      (in_strip)
    );

    function automatic logic [7:0] rom_fn(input int col, input int num, input int addr);
        int s;
        if (num == 4) return 8'hFF;
        s = addr * 7 + col * 41 + num * 13 + 1;
        return s[7:0];
    endfunction

    always @(posedge clk) rom_data <= rom_fn(int'(rom_color), int'(rom_number), int'(rom_addr));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            cur_c[i] = 0;
            cur_n[i] = 4;
        end
        snap_c = 0;
        snap_n = 4;
        armed  = 0;
        q.delete();
        for (int i = 0; i < 2; i++) q.push_back('{v: 1'b0, s: 1'b0, pix: BG});
    endtask

    task automatic step(input int x, input int y, input bit pv,
                        input bit we = 0, input int idx = 0, input int col = 0, input int num = 0);
        bit   row, strip, brd;
        int   dx, ty, tx, sl, e_addr, e_num, e_pix;
        exp_t e;
        row = (y >= ORG_Y) && (y < ORG_Y + TILE);
        if (pv && row && x == ORG_X) armed = 1;
        strip = armed && pv && row && (x >= ORG_X) && (x < ORG_X + NSLOT * TILE);
        dx = x - ORG_X;
        ty = y - ORG_Y;
        tx = dx % TILE;
        sl = dx / TILE;
        if (strip && tx == 0) begin
            snap_c = cur_c[sl];
            snap_n = cur_n[sl];
        end
        e_addr = strip ? ty * TILE + tx : 0;
        e_num  = strip ? snap_n : 4;
        brd    = 0;
`ifdef TILE_BORDER_EN
        brd = (tx == 0) || (tx == TILE - 1) || (ty == 0) || (ty == TILE - 1);
`endif
        e_pix = !strip ? BG : (brd ? 255 : int'(rom_fn(snap_c, snap_n, e_addr)));
        if (armed && x >= ORG_X + NSLOT * TILE) armed = 0;
        if (we) begin
            cur_c[idx] = col;
            cur_n[idx] = num;
        end
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        pix_valid   = pv;
        slot_we     = we;
        slot_idx    = 3'(idx);
        slot_color  = 2'(col);
        slot_number = 3'(num);
        @(posedge clk);
        #1;
        slot_we = 1'b0;
        check("rom_addr", int'(rom_addr), e_addr);
        check("rom_number", int'(rom_number), e_num);
        if (strip) check("rom_color", int'(rom_color), snap_c);
        q.push_back('{v: pv, s: strip, pix: e_pix});
        e = q.pop_front();
        check("pix_out_valid", int'(pix_out_valid), int'(e.v));
        check("in_strip", int'(in_strip), int'(e.s));
        check("pix_out", int'(pix_out), e.pix);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        pix_x = '0; pix_y = '0; pix_valid = 1'b0;
        slot_we = 1'b0; slot_idx = '0; slot_color = '0; slot_number = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_rom_color", int'(rom_color), 0);
        check("rst_rom_number", int'(rom_number), 4);
        check("rst_pix_out", int'(pix_out), BG);
        check("rst_pix_out_valid", int'(pix_out_valid), 0);
        check("rst_in_strip", int'(in_strip), 0);
        rst = 1'b0;

        // blank strip across a full line
        for (int x = 0; x < 640; x++) begin
            step(x, ORG_Y, 1);
            if (x == ORG_X + 2) check("corner_pix", int'(pix_out), 255);
        end
        idle(5);

        step(0, 0, 0, 1, 2, 2, 3);
        step(0, 0, 0, 1, 7, 3, 1);
        idle(2);

        for (int x = 95; x < 346; x++) begin
            step(x, ORG_Y + 5, 1);
            if (x == ORG_X + 67) begin
                check("s2_addr", int'(rom_addr), 157);
                check("s2_color", int'(rom_color), 2);
                check("s2_number", int'(rom_number), 3);
            end
            if (x == ORG_X + 69) begin
                check("s2_pix_lat3", int'(pix_out), int'(rom_fn(2, 3, 157)));
                check("s2_in_strip", int'(in_strip), 1);
            end
        end
        idle(5);

        for (int x = 95; x < 346; x++) begin
            step(x, ORG_Y + 29, 1);
            if (x == ORG_X + 239) begin
                check("last_addr", int'(rom_addr), 899);
                check("last_color", int'(rom_color), 3);
                check("last_number", int'(rom_number), 1);
            end
            if (x == ORG_X + 242) begin
                check("past_in_strip", int'(in_strip), 0);
                check("past_pix", int'(pix_out), BG);
            end
        end
        idle(5);

        // write slot 1 while its tile is being drawn
        for (int x = 95; x < 346; x++) begin
            step(x, ORG_Y + 10, 1, x == ORG_X + 40, 1, 1, 2);
            if (x == ORG_X + 50) check("wr_old_number", int'(rom_number), 4);
        end
        idle(5);
        for (int x = 95; x < 346; x++) begin
            step(x, ORG_Y + 11, 1);
            if (x == ORG_X + 50) begin
                check("wr_new_number", int'(rom_number), 2);
                check("wr_new_color", int'(rom_color), 1);
            end
        end
        idle(5);

        // pix_valid gap inside tile 3
        for (int x = 95; x < 346; x++) begin
            if (x == ORG_X + 100) begin
                for (int g = 0; g < 4; g++) step(x, ORG_Y + 12, 0);
            end
            step(x, ORG_Y + 12, 1);
            if (x == ORG_X + 100) check("gap_resume_addr", int'(rom_addr), 370);
        end
        idle(5);

        // asynchronous reset mid-strip
        for (int x = 95; x < 346; x++) begin
            step(x, ORG_Y + 13, 1);
            if (x == ORG_X + 150) begin
                #2 rst = 1'b1;
                #1;
                check("arst_rom_addr", int'(rom_addr), 0);
                check("arst_rom_number", int'(rom_number), 4);
                check("arst_pix_out_valid", int'(pix_out_valid), 0);
                check("arst_in_strip", int'(in_strip), 0);
                check("arst_pix_out", int'(pix_out), BG);
                #1 rst = 1'b0;
                model_reset();
            end
        end
        idle(5);

        for (int x = 95; x < 346; x++) begin
            step(x, ORG_Y, 1);
            if (x == ORG_X + 2) check("post_rst_corner", int'(pix_out), 255);
            if (x == ORG_X + 67) check("post_rst_blank", int'(rom_number), 4);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
